multibyte_add_seq: RTL and testbench

- Sequencer that adds two NBYTES-wide operands using the team's 8-bit combinational full adder, one byte per clock, LSB byte first.
- Sits directly around the adder:
  - drives the adder's num1/num2/c_in inputs;
  - consumes its sum/c_out outputs;
  - chains carry between bytes;
  - assembles the wide result.
- Adder instance is external; this block holds all state.

---
 rtl/multibyte_add_seq.sv | 138 +++++++++++++
 tb/tb_multibyte_add_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder sequencer around an external 8-bit full adder, LSB byte first.
// Optional subtract mode is enabled by defining MULTIBYTE_ADD_SEQ_SUB_EN.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                carry_in,
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic [7:0]          add_num1,
  output logic [7:0]          add_num2,
  output logic                add_c_in,
  input  logic [7:0]          add_sum,
  input  logic                add_c_out
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [8*NBYTES-1:0] a_q, a_d, b_q, b_d;
  logic [8*NBYTES-1:0] result_q, result_d;
  logic                carry_out_q, carry_out_d;
  logic                last_byte;
  logic                accept;
  logic                init_carry;
  logic [7:0]          b_byte;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  logic                sub_q, sub_d;
`endif

  assign last_byte = (idx_q == IW'(NBYTES - 1));
  assign accept    = (state_q == IDLE) && start;

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  // Two's-complement subtract: invert B and seed the chain with 1
  assign init_carry = sub ? 1'b1 : carry_in;
  assign b_byte     = sub_q ? ~b_q[idx_q*8 +: 8] : b_q[idx_q*8 +: 8];
`else
  assign init_carry = carry_in;
  assign b_byte     = b_q[idx_q*8 +: 8];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_byte) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    sub_d       = sub_q;
`endif
    if (accept) begin
      a_d         = op_a;
      b_d         = op_b;
      carry_d     = init_carry;
      idx_d       = '0;
      result_d    = '0;
      carry_out_d = 1'b0;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
      sub_d       = sub;
`endif
    end else if (state_q == RUN) begin
      result_d[idx_q*8 +: 8] = add_sum;
      carry_d                = add_c_out;
      // Final carry latched separately so it holds alongside result after DONE
      if (last_byte) carry_out_d = add_c_out;
      else           idx_d       = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    result    = result_q;
    carry_out = carry_out_q;
    add_num1  = 8'h00;
    add_num2  = 8'h00;
    add_c_in  = 1'b0;
    if (state_q == RUN) begin
      add_num1 = a_q[idx_q*8 +: 8];
      add_num2 = b_byte;
      add_c_in = carry_q;
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq (NBYTES=4) with a behavioural 8-bit adder attached.
module tb_multibyte_add_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        carry_in;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  logic        sub;
`endif
  logic        busy, done, carry_out;
  logic [31:0] result;
  logic [7:0]  add_num1, add_num2, add_sum;
  logic        add_c_in, add_c_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign {add_c_out, add_sum} = {1'b0, add_num1} + {1'b0, add_num2} + {8'h00, add_c_in};

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .carry_in(carry_in),
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .add_num1(add_num1), .add_num2(add_num2), .add_c_in(add_c_in),
    .add_sum(add_sum), .add_c_out(add_c_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One full operation; operands are scrambled right after accept to prove capture.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [7:0] n2, input logic c0,
                        input logic c1, input logic [31:0] er, input logic ec);
    int n;
    op_a = a; op_b = b; carry_in = ci; start = 1'b1;
    tick();
    start = 1'b0; op_a = '0; op_b = '1; carry_in = ~ci;
    chk({tag, ":busy"}, busy, 1);
    chk({tag, ":res_clr"}, result, 0);
    chk({tag, ":co_clr"}, carry_out, 0);
    chk({tag, ":num1_b0"}, add_num1, a[7:0]);
    chk({tag, ":num2_b0"}, add_num2, n2);
    chk({tag, ":cin_b0"}, add_c_in, c0);
    tick();
    n = 1;
    chk({tag, ":cin_b1"}, add_c_in, c1);
    while (!done && n < 20) begin tick(); n++; end
    chk({tag, ":latency"}, n, 4);
    chk({tag, ":result"}, result, er);
    chk({tag, ":carry"}, carry_out, ec);
    tick();
    chk({tag, ":done_pulse"}, done, 0);
    chk({tag, ":idle"}, busy, 0);
    chk({tag, ":held"}, {31'b0, carry_out, result}, {31'b0, ec, er});
  endtask

  initial begin
    int n, d0, d1, nd;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:result", result, 0);
    chk("rst:carry", carry_out, 0);
    chk("rst:adder", {add_num1, add_num2, add_c_in}, 0);
    rst_n = 1'b1;
    tick();

    run_op("ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 0, 8'h01, 0, 1, 32'h0000_0100, 0);
    run_op("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 0, 8'h01, 0, 1, 32'h0000_0000, 1);
    run_op("cin1",      32'h1234_5678, 32'h1111_1111, 1, 8'h11, 1, 0, 32'h2345_678A, 0);
    run_op("all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 8'hFF, 1, 1, 32'hFFFF_FFFF, 1);

    // Second start during RUN is ignored
    op_a = 32'h8000_0000; op_b = 32'h8000_0000; carry_in = 0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    n = 3;
    while (!done && n < 20) begin tick(); n++; end
    chk("ign:latency", n, 4);
    chk("ign:result", result, 32'h0000_0000);
    chk("ign:carry", carry_out, 1);
    nd = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (done) nd++; end
    chk("ign:no_extra_done", nd, 0);
    chk("ign:held", result, 32'h0000_0000);

    // Start held high: back-to-back operations
    op_a = 32'h0102_0304; op_b = 32'h1020_3040; carry_in = 0; start = 1'b1;
    d0 = -1; d1 = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) begin
        if (d0 < 0) d0 = i;
        else if (d1 < 0) d1 = i;
      end
    end
    start = 1'b0;
    chk("b2b:period", d1 - d0, 6);
    chk("b2b:first_done", d0, 4);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("b2b:result", result, 32'h1122_3344);
    chk("b2b:idle", busy, 0);

    // Reset during the third RUN cycle aborts cleanly
    op_a = 32'h1111_1111; op_b = 32'h2222_2222; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("abort:busy_pre", busy, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("abort:busy", busy, 0);
    chk("abort:done", done, 0);
    chk("abort:result", result, 0);
    chk("abort:carry", carry_out, 0);
    chk("abort:adder", {add_num1, add_num2, add_c_in}, 0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (done) nd++; end
    chk("abort:no_done", nd, 0);

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    sub = 1'b1;
    run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 0, 8'hF8, 1, 0, 32'hFFFF_FFFE, 0);
    run_op("sub_ok",     32'h0000_0007, 32'h0000_0005, 0, 8'hFA, 1, 1, 32'h0000_0002, 1);
    sub = 1'b0;
    run_op("sub0_add",   32'h0000_0007, 32'h0000_0005, 0, 8'h05, 0, 0, 32'h0000_000C, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
